hist_stream_rx: RTL and testbench

HIST_STREAM_RX -- requirements
Module: hist_stream_rx

---
 rtl/hist_stream_rx.sv | 135 +++++++++++++
 tb/tb_hist_stream_rx.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/hist_stream_rx.sv
// Receives one histogram frame per acknowledge cycle, stores the bins in a
// small RAM and keeps running count / total / peak statistics for the frame.
module hist_stream_rx #(
   parameter int NUM_BINS = 16,
   parameter int AW       = 4
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic [7:0]    bin_data,
   input  logic          bin_valid,
   input  logic          bin_last,
   input  logic          clear,
   input  logic          rd_en,
   input  logic [AW-1:0] rd_addr,
   output logic [7:0]    rd_data,
   output logic          rd_valid,
   output logic          frame_done,
   output logic [AW:0]   bin_count,
   output logic [AW-1:0] peak_idx,
   output logic [7:0]    peak_val,
   output logic [AW+7:0] total,
   output logic          overflow,
   output logic          missed
);

   typedef enum logic [1:0] {IDLE, RECV, DONE} state_t;

   state_t          state_reg;
   logic [AW:0]     count_reg;
   logic [AW+7:0]   total_reg;
   logic [AW-1:0]   peak_idx_reg;
   logic [7:0]      peak_val_reg;
   logic            overflow_reg;
   logic            missed_reg;
   logic [7:0]      rd_data_reg;
   logic            rd_valid_reg;

   logic [7:0]      mem [NUM_BINS];

   logic            full;
   logic            beat;
   logic            store;
   logic            first;
   logic [AW-1:0]   wr_addr;

   // The stored-bin count doubles as the write pointer.
   assign full    = (count_reg == (AW+1)'(NUM_BINS));
   assign beat    = bin_valid && !clear;
   assign store   = beat && ((state_reg == IDLE) || ((state_reg == RECV) && !full));
   assign first   = (count_reg == '0);
   assign wr_addr = count_reg[AW-1:0];

   always_ff @(posedge clk) begin
      if (store) begin
         mem[wr_addr] <= bin_data;
      end
   end

   // Registered read port; a same-cycle write is seen only on the next read.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_data_reg  <= '0;
         rd_valid_reg <= 1'b0;
      end else begin
         rd_valid_reg <= rd_en;
         if (rd_en) begin
            rd_data_reg <= mem[rd_addr];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg    <= IDLE;
         count_reg    <= '0;
         total_reg    <= '0;
         peak_idx_reg <= '0;
         peak_val_reg <= '0;
         overflow_reg <= 1'b0;
         missed_reg   <= 1'b0;
      end else if (clear) begin
         state_reg    <= IDLE;
         count_reg    <= '0;
         total_reg    <= '0;
         peak_idx_reg <= '0;
         peak_val_reg <= '0;
         overflow_reg <= 1'b0;
         missed_reg   <= 1'b0;
      end else begin
         if (store) begin
            count_reg <= count_reg + (AW+1)'(1);
            total_reg <= total_reg + {{AW{1'b0}}, bin_data};
            // Strict compare keeps the lowest index on ties.
            if (first || (bin_data > peak_val_reg)) begin
               peak_val_reg <= bin_data;
               peak_idx_reg <= wr_addr;
            end
         end
         case (state_reg)
            IDLE: begin
               if (bin_valid) begin
                  state_reg <= bin_last ? DONE : RECV;
               end
            end
            RECV: begin
               if (bin_valid) begin
                  if (full) begin
                     overflow_reg <= 1'b1;
                  end
                  if (bin_last) begin
                     state_reg <= DONE;
                  end
               end
            end
            DONE: begin
               if (bin_valid) begin
                  missed_reg <= 1'b1;
               end
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

   assign rd_data    = rd_data_reg;
   assign rd_valid   = rd_valid_reg;
   assign frame_done = (state_reg == DONE);
   assign bin_count  = count_reg;
   assign peak_idx   = peak_idx_reg;
   assign peak_val   = peak_val_reg;
   assign total      = total_reg;
   assign overflow   = overflow_reg;
   assign missed     = missed_reg;

endmodule

// File: tb/tb_hist_stream_rx.sv
// Self-checking bench for hist_stream_rx: frame statistics, flags, clear,
// asynchronous reset and RAM read-back through an expected-value queue.
module tb_hist_stream_rx;

   localparam int NUM_BINS = 16;
   localparam int AW       = 4;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [7:0]    bin_data;
   logic          bin_valid;
   logic          bin_last;
   logic          clear;
   logic          rd_en;
   logic [AW-1:0] rd_addr;
   logic [7:0]    rd_data;
   logic          rd_valid;
   logic          frame_done;
   logic [AW:0]   bin_count;
   logic [AW-1:0] peak_idx;
   logic [7:0]    peak_val;
   logic [AW+7:0] total;
   logic          overflow;
   logic          missed;

   int errors = 0;
   int checks = 0;
   logic [7:0] mdl [NUM_BINS];
   logic [7:0] exp_q [$];

   hist_stream_rx #(.NUM_BINS(NUM_BINS), .AW(AW)) dut (
      .clk(clk), .rst_n(rst_n), .bin_data(bin_data), .bin_valid(bin_valid),
      .bin_last(bin_last), .clear(clear), .rd_en(rd_en), .rd_addr(rd_addr),
      .rd_data(rd_data), .rd_valid(rd_valid), .frame_done(frame_done),
      .bin_count(bin_count), .peak_idx(peak_idx), .peak_val(peak_val),
      .total(total), .overflow(overflow), .missed(missed)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic beat(input logic [7:0] d, input logic last, input logic clr);
      bin_data  = d;
      bin_valid = 1'b1;
      bin_last  = last;
      clear     = clr;
      step();
      bin_valid = 1'b0;
      bin_last  = 1'b0;
      clear     = 1'b0;
   endtask

   task automatic do_clear();
      clear = 1'b1;
      step();
      clear = 1'b0;
   endtask

   task automatic check_stats(input string name, input logic done, input int cnt,
                              input int tot, input int pidx, input int pval,
                              input logic ovf, input logic mis);
      checks++;
      if (frame_done !== done || bin_count !== (AW+1)'(cnt) || total !== (AW+8)'(tot) ||
          peak_idx !== AW'(pidx) || peak_val !== 8'(pval) || overflow !== ovf || missed !== mis) begin
         errors++;
         $display("FAIL %s: got done=%b cnt=%0d tot=%0d pidx=%0d pval=%0d ovf=%b mis=%b, want done=%b cnt=%0d tot=%0d pidx=%0d pval=%0d ovf=%b mis=%b",
                  name, frame_done, bin_count, total, peak_idx, peak_val, overflow, missed,
                  done, cnt, tot, pidx, pval, ovf, mis);
      end else begin
         $display("check %s: done=%b cnt=%0d tot=%0d pidx=%0d pval=%0d ovf=%b mis=%b",
                  name, frame_done, bin_count, total, peak_idx, peak_val, overflow, missed);
      end
   endtask

   // Pop one expected read result and compare against the current read port.
   task automatic pop_read(input string name);
      logic [7:0] e;
      checks++;
      if (exp_q.size() == 0) begin
         errors++;
         $display("FAIL %s: read scoreboard empty, got valid=%b data=%0d", name, rd_valid, rd_data);
      end else begin
         e = exp_q.pop_front();
         if (rd_valid !== 1'b1 || rd_data !== e) begin
            errors++;
            $display("FAIL %s: got valid=%b data=%0d, want valid=1 data=%0d", name, rd_valid, rd_data, e);
         end else begin
            $display("check %s: data=%0d", name, rd_data);
         end
      end
   endtask

   task automatic read_bins(input string name, input int n);
      for (int i = 0; i < n; i++) begin
         rd_en   = 1'b1;
         rd_addr = AW'(i);
         exp_q.push_back(mdl[i]);
         step();
         pop_read(name);
      end
      rd_en = 1'b0;
      step();
      checks++;
      if (rd_valid !== 1'b0 || exp_q.size() != 0) begin
         errors++;
         $display("FAIL %s_idle: got valid=%b pending=%0d, want valid=0 pending=0", name, rd_valid, exp_q.size());
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b1;
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if (rd_data !== 8'd0 || rd_valid !== 1'b0) begin
         errors++;
         $display("FAIL reset_rd: got data=%0d valid=%b, want 0 0", rd_data, rd_valid);
      end
      check_stats("reset", 1'b0, 0, 0, 0, 0, 1'b0, 1'b0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      step();
   endtask

   task automatic test_normal_frame();
      beat(8'd5, 1'b0, 1'b0); mdl[0] = 8'd5;
      beat(8'd9, 1'b0, 1'b0); mdl[1] = 8'd9;
      beat(8'd9, 1'b0, 1'b0); mdl[2] = 8'd9;
      check_stats("normal_mid", 1'b0, 3, 23, 1, 9, 1'b0, 1'b0);
      beat(8'd3, 1'b1, 1'b0); mdl[3] = 8'd3;
      check_stats("normal_done", 1'b1, 4, 26, 1, 9, 1'b0, 1'b0);
      read_bins("normal_rd", 4);
      do_clear();
   endtask

   task automatic test_single_beat();
      beat(8'd200, 1'b1, 1'b0); mdl[0] = 8'd200;
      check_stats("single", 1'b1, 1, 200, 0, 200, 1'b0, 1'b0);
      read_bins("single_rd", 1);
      do_clear();
      check_stats("single_clr", 1'b0, 0, 0, 0, 0, 1'b0, 1'b0);
   endtask

   task automatic test_overflow();
      for (int i = 0; i < 16; i++) begin
         beat(8'd255, 1'b0, 1'b0);
         mdl[i] = 8'd255;
      end
      check_stats("ovf_full", 1'b0, 16, 4080, 0, 255, 1'b0, 1'b0);
      beat(8'd255, 1'b0, 1'b0);
      check_stats("ovf_17", 1'b0, 16, 4080, 0, 255, 1'b1, 1'b0);
      beat(8'd255, 1'b1, 1'b0);
      check_stats("ovf_done", 1'b1, 16, 4080, 0, 255, 1'b1, 1'b0);
      do_clear();
   endtask

   task automatic test_held_clear();
      beat(8'd10, 1'b0, 1'b0); mdl[0] = 8'd10;
      beat(8'd20, 1'b1, 1'b0); mdl[1] = 8'd20;
      check_stats("held", 1'b1, 2, 30, 1, 20, 1'b0, 1'b0);
      beat(8'd99, 1'b0, 1'b0);
      check_stats("held_missed", 1'b1, 2, 30, 1, 20, 1'b0, 1'b1);
      beat(8'd77, 1'b1, 1'b1);
      check_stats("clear_beat", 1'b0, 0, 0, 0, 0, 1'b0, 1'b0);
      read_bins("clear_rd", 2);
   endtask

   task automatic test_read_during_write();
      rd_en   = 1'b1;
      rd_addr = '0;
      exp_q.push_back(mdl[0]);
      beat(8'd50, 1'b1, 1'b0);
      rd_en = 1'b0;
      pop_read("rdw_old");
      mdl[0] = 8'd50;
      check_stats("rdw_frame", 1'b1, 1, 50, 0, 50, 1'b0, 1'b0);
      read_bins("rdw_new", 1);
      do_clear();
   endtask

   task automatic test_async_reset();
      beat(8'd1, 1'b0, 1'b0);
      beat(8'd2, 1'b0, 1'b0);
      check_stats("pre_reset", 1'b0, 2, 3, 1, 2, 1'b0, 1'b0);
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if (rd_data !== 8'd0 || rd_valid !== 1'b0) begin
         errors++;
         $display("FAIL async_rd: got data=%0d valid=%b, want 0 0", rd_data, rd_valid);
      end
      check_stats("async_reset", 1'b0, 0, 0, 0, 0, 1'b0, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      step();
      beat(8'd7, 1'b1, 1'b0); mdl[0] = 8'd7;
      check_stats("post_reset", 1'b1, 1, 7, 0, 7, 1'b0, 1'b0);
      read_bins("post_rd", 1);
   endtask

   initial begin
      bin_data  = '0;
      bin_valid = 1'b0;
      bin_last  = 1'b0;
      clear     = 1'b0;
      rd_en     = 1'b0;
      rd_addr   = '0;
      test_reset();
      test_normal_frame();
      test_single_beat();
      test_overflow();
      test_held_clear();
      test_read_during_write();
      test_async_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish, want completion");
      $fatal(1);
   end

endmodule
